// File: rtl/pe_execute.sv
// Execute stage of the SIMD PE: operand registers with fetch forwarding,
// a one-cycle element-wise ALU and a two-stage pipelined dot product.
module pe_execute #(
  parameter int unsigned OPCODE_LEN  = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PE_ELEMENTS = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              valid,
  input  logic [OPCODE_LEN-1:0]             opcode,
  input  logic [PE_ELEMENTS*DATA_WIDTH-1:0] data_a,
  input  logic [PE_ELEMENTS*DATA_WIDTH-1:0] data_b,
  output logic                              pe_stage_1_valid,
  output logic [PE_ELEMENTS*DATA_WIDTH-1:0] pe_stage_1_output,
  output logic                              pe_stage_2_valid,
  output logic [DATA_WIDTH-1:0]             pe_stage_2_output,
  output logic                              store_result,
  output logic                              halted
);

  typedef enum logic [OPCODE_LEN-1:0] {
    OP_NOOP          = OPCODE_LEN'(0),
    OP_ADD           = OPCODE_LEN'(1),
    OP_SUB           = OPCODE_LEN'(2),
    OP_MUL           = OPCODE_LEN'(3),
    OP_DOTP          = OPCODE_LEN'(4),
    OP_STORE_TEMP_S1 = OPCODE_LEN'(5),
    OP_STORE_TEMP_S2 = OPCODE_LEN'(6),
    OP_STORE_RESULT  = OPCODE_LEN'(7),
    OP_STOP          = OPCODE_LEN'(8),
    OP_FETCH_A       = OPCODE_LEN'(9),
    OP_FETCH_B       = OPCODE_LEN'(10)
  } opcode_e;

  opcode_e               op;
  logic                  accept;
  logic                  is_fetch_a, is_fetch_b, is_alu, is_dotp, is_store, is_stop;

  logic [DATA_WIDTH-1:0] opa_q   [PE_ELEMENTS];
  logic [DATA_WIDTH-1:0] opb_q   [PE_ELEMENTS];
  logic [DATA_WIDTH-1:0] a_eff   [PE_ELEMENTS];
  logic [DATA_WIDTH-1:0] b_eff   [PE_ELEMENTS];
  logic [DATA_WIDTH-1:0] s1_d    [PE_ELEMENTS];
  logic [DATA_WIDTH-1:0] s1_q    [PE_ELEMENTS];
  logic [DATA_WIDTH-1:0] prod_d  [PE_ELEMENTS];
  logic [DATA_WIDTH-1:0] prod_q  [PE_ELEMENTS];
  logic [DATA_WIDTH-1:0] dotp_sum;
  logic [DATA_WIDTH-1:0] s2_q;

  logic fwd_a_q, fwd_b_q;
  logic s1_valid_q, dotp_v_q, s2_valid_q, store_q, halted_q;

  assign op     = opcode_e'(opcode);
  assign accept = valid & ~halted_q;

  always_comb begin
    is_fetch_a = 1'b0;
    is_fetch_b = 1'b0;
    is_alu     = 1'b0;
    is_dotp    = 1'b0;
    is_store   = 1'b0;
    is_stop    = 1'b0;
    if (accept) begin
      case (op)
        OP_ADD, OP_SUB, OP_MUL: is_alu     = 1'b1;
        OP_DOTP:                is_dotp    = 1'b1;
        OP_STORE_RESULT:        is_store   = 1'b1;
        OP_STOP:                is_stop    = 1'b1;
        OP_FETCH_A:             is_fetch_a = 1'b1;
        OP_FETCH_B:             is_fetch_b = 1'b1;
        default:                ;
      endcase
    end
  end

  // While a fetch is returning, the DRAM bus is the freshest copy of the operand.
  always_comb begin
    for (int unsigned i = 0; i < PE_ELEMENTS; i++) begin
      a_eff[i]  = fwd_a_q ? data_a[i*DATA_WIDTH +: DATA_WIDTH] : opa_q[i];
      b_eff[i]  = fwd_b_q ? data_b[i*DATA_WIDTH +: DATA_WIDTH] : opb_q[i];
      prod_d[i] = a_eff[i] * b_eff[i];
      case (op)
        OP_SUB:  s1_d[i] = a_eff[i] - b_eff[i];
        OP_MUL:  s1_d[i] = prod_d[i];
        default: s1_d[i] = a_eff[i] + b_eff[i];
      endcase
    end
  end

  always_comb begin
    dotp_sum = '0;
    for (int unsigned i = 0; i < PE_ELEMENTS; i++) begin
      dotp_sum = dotp_sum + prod_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_q    <= 1'b0;
      fwd_b_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      dotp_v_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      store_q    <= 1'b0;
      halted_q   <= 1'b0;
      s2_q       <= '0;
      for (int unsigned i = 0; i < PE_ELEMENTS; i++) begin
        opa_q[i]  <= '0;
        opb_q[i]  <= '0;
        s1_q[i]   <= '0;
        prod_q[i] <= '0;
      end
    end else begin
      fwd_a_q    <= is_fetch_a;
      fwd_b_q    <= is_fetch_b;
      s1_valid_q <= is_alu;
      dotp_v_q   <= is_dotp;
      s2_valid_q <= dotp_v_q;
      store_q    <= is_store;
      halted_q   <= halted_q | is_stop;
      if (dotp_v_q) s2_q <= dotp_sum;
      for (int unsigned i = 0; i < PE_ELEMENTS; i++) begin
        if (fwd_a_q) opa_q[i]  <= data_a[i*DATA_WIDTH +: DATA_WIDTH];
        if (fwd_b_q) opb_q[i]  <= data_b[i*DATA_WIDTH +: DATA_WIDTH];
        if (is_alu)  s1_q[i]   <= s1_d[i];
        if (is_dotp) prod_q[i] <= prod_d[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < PE_ELEMENTS; i++) begin
      pe_stage_1_output[i*DATA_WIDTH +: DATA_WIDTH] = s1_q[i];
    end
  end

  assign pe_stage_1_valid  = s1_valid_q;
  assign pe_stage_2_valid  = s2_valid_q;
  assign pe_stage_2_output = s2_q;
  assign store_result      = store_q;
  assign halted            = halted_q;

endmodule

// File: tb/tb_pe_execute.sv
// Scoreboard bench for pe_execute: directed scenarios followed by random opcode streams.
module tb_pe_execute;
  localparam int DW = 32;
  localparam int PE = 4;
  typedef logic [PE*DW-1:0] vec_t;
  typedef struct { int due; vec_t val; } exp_t;

  localparam logic [3:0] NOOP = 4'd0, ADD = 4'd1, SUB = 4'd2, MUL = 4'd3, DOTP = 4'd4,
                         STR = 4'd7, STOP = 4'd8, FA = 4'd9, FB = 4'd10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [3:0] opcode = '0;
  vec_t       data_a = '0, data_b = '0;
  logic       pe_stage_1_valid, pe_stage_2_valid, store_result, halted;
  vec_t       pe_stage_1_output;
  logic [DW-1:0] pe_stage_2_output;

  pe_execute #(.OPCODE_LEN(4), .DATA_WIDTH(DW), .PE_ELEMENTS(PE)) dut (
    .clk(clk), .rst(rst), .valid(valid), .opcode(opcode),
    .data_a(data_a), .data_b(data_b),
    .pe_stage_1_valid(pe_stage_1_valid), .pe_stage_1_output(pe_stage_1_output),
    .pe_stage_2_valid(pe_stage_2_valid), .pe_stage_2_output(pe_stage_2_output),
    .store_result(store_result), .halted(halted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int     n_tests = 0;
  int     n_fail  = 0;
  logic   mon_en  = 1'b0;
  exp_t   q [3][$];
  vec_t   hold [2];
  string  nm [3] = '{"s1", "s2", "store"};

  // Reference model state
  vec_t m_opa = '0, m_opb = '0;
  logic m_fwd_a = 1'b0, m_fwd_b = 1'b0, m_halted = 1'b0;

  task automatic chk(input string name, input vec_t act, input vec_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [DW-1:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    for (int i = 0; i < PE; i++) v[i*DW +: DW] = ($urandom_range(0, 7) == 0) ? '1 : $urandom;
    return v;
  endfunction

  function automatic vec_t lanewise(input logic [3:0] op, input vec_t a, input vec_t b);
    vec_t r;
    logic [DW-1:0] x, y;
    for (int i = 0; i < PE; i++) begin
      x = a[i*DW +: DW];
      y = b[i*DW +: DW];
      case (op)
        ADD:     r[i*DW +: DW] = x + y;
        SUB:     r[i*DW +: DW] = x - y;
        default: r[i*DW +: DW] = x * y;
      endcase
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] dot(input vec_t a, input vec_t b);
    logic [DW-1:0] s = '0, p;
    for (int i = 0; i < PE; i++) begin
      p = a[i*DW +: DW] * b[i*DW +: DW];
      s = s + p;
    end
    return s;
  endfunction

  // One clock cycle of stimulus; the model predicts responses and queues them.
  task automatic step(input logic v, input logic [3:0] op, input vec_t da, input vec_t db,
                      input logic r);
    vec_t a, b;
    logic acc;
    int   c;
    c = cyc;
    rst = r; valid = v; opcode = op; data_a = da; data_b = db;
    chk("halted", vec_t'(halted), vec_t'(m_halted));
    if (r) begin
      m_opa = '0; m_opb = '0; m_fwd_a = 1'b0; m_fwd_b = 1'b0; m_halted = 1'b0;
      for (int k = 0; k < 3; k++)
        while (q[k].size() > 0 && q[k][$].due > c) void'(q[k].pop_back());
    end else begin
      a = m_fwd_a ? da : m_opa;
      b = m_fwd_b ? db : m_opb;
      if (m_fwd_a) m_opa = da;
      if (m_fwd_b) m_opb = db;
      acc = v && !m_halted;
      m_fwd_a = acc && op == FA;
      m_fwd_b = acc && op == FB;
      if (acc) begin
        case (op)
          ADD, SUB, MUL: q[0].push_back('{c + 1, lanewise(op, a, b)});
          DOTP:          q[1].push_back('{c + 2, vec_t'(dot(a, b))});
          STR:           q[2].push_back('{c + 1, '0});
          STOP:          m_halted = 1'b1;
          default:       ;
        endcase
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic op1(input logic [3:0] op);
    step(1'b1, op, rnd_vec(), rnd_vec(), 1'b0);
  endtask

  task automatic load(input vec_t va, input vec_t vb);
    step(1'b1, FA, rnd_vec(), rnd_vec(), 1'b0);
    step(1'b1, FB, va, rnd_vec(), 1'b0);
    step(1'b1, NOOP, rnd_vec(), vb, 1'b0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        logic vld, due_now;
        vec_t act;
        exp_t e;
        case (k)
          0:       begin vld = pe_stage_1_valid; act = pe_stage_1_output; end
          1:       begin vld = pe_stage_2_valid; act = vec_t'(pe_stage_2_output); end
          default: begin vld = store_result;     act = '0; end
        endcase
        due_now = q[k].size() > 0 && q[k][0].due == cyc;
        chk({nm[k], "_valid"}, vec_t'(vld), vec_t'(due_now));
        if (due_now) begin
          e = q[k].pop_front();
          if (vld && k < 2) begin
            chk({nm[k], "_value"}, act, e.val);
            hold[k] = e.val;
          end
        end else if (k < 2) begin
          chk({nm[k], "_hold"}, act, hold[k]);
        end
      end
      if (rst) begin
        hold[0] = '0;
        hold[1] = '0;
      end
    end
  end

  initial begin
    int r;
    logic [3:0] op;
    hold[0] = '0;
    hold[1] = '0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    step(1'b0, NOOP, '0, '0, 1'b1);
    chk("reset_s1_out", pe_stage_1_output, '0);
    chk("reset_s2_out", vec_t'(pe_stage_2_output), '0);

    // Forwarding: ADD right after FETCH_B sees both new operands
    step(1'b1, FA, rnd_vec(), rnd_vec(), 1'b0);
    step(1'b1, FB, mk(1, 2, 3, 4), rnd_vec(), 1'b0);
    step(1'b1, ADD, rnd_vec(), mk(10, 20, 30, 40), 1'b0);
    chk("fwd_add", pe_stage_1_output, mk(11, 22, 33, 44));

    // Wrap-around
    load(mk(32'hFFFF_FFFF, 0, 5, 32'h8000_0000), mk(1, 1, 7, 2));
    op1(SUB);
    chk("wrap_sub", pe_stage_1_output, mk(32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h7FFF_FFFE));
    op1(MUL);
    chk("wrap_mul", pe_stage_1_output, mk(32'hFFFF_FFFF, 0, 35, 0));

    // DOTP latency, hold, back-to-back
    load(mk(1, 2, 3, 4), mk(5, 6, 7, 8));
    op1(DOTP);
    op1(NOOP);
    chk("dotp_70", vec_t'(pe_stage_2_output), vec_t'(70));
    op1(NOOP);
    op1(DOTP); op1(DOTP); op1(DOTP); op1(NOOP); op1(NOOP); op1(NOOP);

    // Overlap with store strobe
    op1(DOTP); op1(MUL); op1(STR); op1(NOOP); op1(NOOP);

    // Valid/halt gating
    step(1'b0, ADD, rnd_vec(), rnd_vec(), 1'b0);
    op1(NOOP);
    op1(DOTP); op1(STOP); op1(NOOP); op1(ADD); op1(NOOP); op1(NOOP);
    chk("halted_sticky", vec_t'(halted), vec_t'(1));
    step(1'b1, NOOP, rnd_vec(), rnd_vec(), 1'b1);
    op1(NOOP);

    // Reset while DOTP is in flight
    load(mk(3, 3, 3, 3), mk(4, 4, 4, 4));
    op1(DOTP);
    step(1'b1, NOOP, rnd_vec(), rnd_vec(), 1'b1);
    chk("rst_s2_out", vec_t'(pe_stage_2_output), '0);
    op1(NOOP); op1(NOOP);

    // Random streams
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) op = STOP;
      else begin
        op = 4'($urandom_range(0, 15));
        if (op == STOP) op = DOTP;
      end
      step($urandom_range(0, 9) != 0, op, rnd_vec(), rnd_vec(), $urandom_range(0, 99) < 3);
    end
    op1(NOOP); op1(NOOP); op1(NOOP);
    for (int k = 0; k < 3; k++) chk({nm[k], "_drained"}, vec_t'(q[k].size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pe_execute.md
Name: pe_execute

Overview:
- Execute stage of the SIMD PE, directly downstream of the fetch/decode stage.
- Consumes the decoded opcode and the A/B vectors returned by the operand DRAMs, and holds the operand registers.
- Produces the element-wise vector result (stage 1) and the pipelined dot-product scalar (stage 2).
- Generates the store_result strobe that the fetch stage uses to write the result DRAM.

Parameters:
OPCODE_LEN, 4, opcode field width
DATA_WIDTH, 32, element width
PE_ELEMENTS, 4, vector lanes (power of two, >=2)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
valid  in  1  opcode qualifier; opcode ignored when 0
opcode  in  OPCODE_LEN  decoded opcode, same cycle as DRAM rd_en
data_a  in  PE_ELEMENTS*DATA_WIDTH  operand-A DRAM read data; valid the cycle after FETCH_A
data_b  in  PE_ELEMENTS*DATA_WIDTH  operand-B DRAM read data; valid the cycle after FETCH_B
pe_stage_1_valid  out  1  one-cycle pulse: pe_stage_1_output updated
pe_stage_1_output  out  PE_ELEMENTS*DATA_WIDTH  element-wise result, held between pulses
pe_stage_2_valid  out  1  one-cycle pulse: pe_stage_2_output updated
pe_stage_2_output  out  DATA_WIDTH  dot-product result, held between pulses
store_result  out  1  one-cycle write strobe for the result DRAM
halted  out  1  high after STOP, until reset

Behaviour:
- Reset: all outputs 0; operand registers opa/opb, the forwarding flags and the DOTP pipeline cleared.
- Opcode encoding:
  - NOOP=0, ADD=1, SUB=2, MUL=3, DOTP=4, STORE_TEMP_S1=5, STORE_TEMP_S2=6, STORE_RESULT=7, STOP=8, FETCH_A=9, FETCH_B=10.
  - Codes 11-15, and STORE_TEMP_S1/S2, behave as NOOP.
- Accept condition: an opcode is accepted only when valid=1 and halted=0. Otherwise it is treated as NOOP, but in-flight pipeline work still completes.
- Operand load: accepted FETCH_A at cycle T sets fwd_a for cycle T+1. At the T+1 edge, opa <= data_a and fwd_a clears. FETCH_B/opb/fwd_b behave the same way.
- Forwarding: during a cycle with fwd_a=1, the effective A operand is data_a rather than opa (same for B). A FETCH_A immediately followed by ADD therefore uses the new data.
- Stage 1 (latency 1):
  - Accepted ADD/SUB/MUL at T: pe_stage_1_output <= lane-wise A+B, A-B or A*B at the T edge; pe_stage_1_valid=1 during T+1.
  - Results are taken modulo 2^DATA_WIDTH; MUL keeps the low DATA_WIDTH bits of each product.
- Stage 2 (latency 2, fully pipelined):
  - Accepted DOTP at T: lane products (low DATA_WIDTH bits) registered at the T edge.
  - Full adder-tree sum registered into pe_stage_2_output at the T+1 edge; pe_stage_2_valid=1 during T+2.
  - Sum wraps modulo 2^DATA_WIDTH.
  - A new DOTP may be accepted every cycle; back-to-back DOTPs produce back-to-back valid pulses.
- Output hold: pe_stage_2_output holds its value for at least the cycle after the valid pulse, since the consumer samples it one cycle late. Outputs change only on their own valid pulse.
- Simultaneous stage 1 and stage 2: DOTP at T and ADD at T+1 both complete during T+2. Both valids are high in that cycle; the outputs are independent.
- STORE_RESULT:
  - Accepted at T: store_result=1 during T+1 only.
  - If a stage-1 or stage-2 result completes in the same cycle as store_result, it is still produced (the consumer gates it).
- STOP:
  - Accepted at T: halted=1 from T+1, sticky.
  - Operations accepted before STOP still complete; a DOTP accepted at T-1 still delivers its pulse.
  - Only rst clears halted.
- Reset mid-operation: rst=1 aborts pending DOTP products, forwarding flags and store_result. No valid pulse follows; outputs return to 0 the cycle after rst.
- Operand registers are unaffected by arithmetic opcodes.

Test Plan:
- Fwd path: rst; FETCH_A with data_a={1,2,3,4} next cycle; FETCH_B with data_b={10,20,30,40}; ADD immediately after FETCH_B -> pe_stage_1_valid pulse, output {11,22,33,44}.
- Wrap: opa={0xFFFFFFFF,0,5,0x80000000}, opb={1,1,7,2}; SUB -> {0xFFFFFFFE,0xFFFFFFFF,0xFFFFFFFE,0x7FFFFFFE}; MUL -> {0xFFFFFFFF,0,35,0}.
- DOTP: opa={1,2,3,4}, opb={5,6,7,8}; DOTP at T -> pe_stage_2_valid only at T+2, output 70, held at T+3. Three back-to-back DOTPs -> three consecutive pulses.
- Overlap: DOTP at T, MUL at T+1 -> both valids high at T+2 with the correct values. STORE_RESULT at T+2 -> store_result high exactly at T+3.
- Halt/valid gating: ADD with valid=0 -> no pulse. DOTP then STOP -> DOTP pulse still produced, halted=1; a later ADD is ignored; rst clears halted.
- Reset mid-DOTP: DOTP at T, rst at T+1 -> no pe_stage_2_valid pulse; all outputs 0 at T+2.
